// File: rtl/ecc_pkg.sv
// Shared types and helpers for the Hamming(12,8) ECC datapath.
// Codeword positions 1..12: parity at 1,2,4,8; data d0..d7 at 3,5,6,7,9,10,11,12.
package ecc_pkg;

  localparam int ECC_DATA_W = 8;
  localparam int ECC_PAR_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    RDATA,
    CHECK,
    WRITE,
    NEXT
  } scrub_state_t;

  function automatic logic [ECC_PAR_W-1:0] ecc_parity(
    input logic [ECC_DATA_W-1:0] d
  );
    logic [ECC_PAR_W-1:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return p;
  endfunction

endpackage

// File: rtl/ecc_decoder.sv
// Hamming(12,8) single-error-correcting decoder.
// The syndrome is the codeword position of the flipped bit.
module ecc_decoder
  import ecc_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] data,
  input  logic [ECC_PAR_W-1:0]  parity,
  output logic [ECC_DATA_W-1:0] corrected_data,
  output logic                  error_detected
);

  logic [ECC_PAR_W-1:0] syn;

  assign syn            = ecc_parity(data) ^ parity;
  assign error_detected = |syn;

  // Positions 1,2,4,8 and 13..15 leave the data untouched.
  always_comb begin
    corrected_data = data;
    case (syn)
      4'd3:    corrected_data[0] = ~data[0];
      4'd5:    corrected_data[1] = ~data[1];
      4'd6:    corrected_data[2] = ~data[2];
      4'd7:    corrected_data[3] = ~data[3];
      4'd9:    corrected_data[4] = ~data[4];
      4'd10:   corrected_data[5] = ~data[5];
      4'd11:   corrected_data[6] = ~data[6];
      4'd12:   corrected_data[7] = ~data[7];
      default: corrected_data = data;
    endcase
  end

endmodule

// File: rtl/ecc_encoder.sv
// Hamming(12,8) parity generator.
// Pure combinational; shares the parity equations with the decoder.
module ecc_encoder
  import ecc_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] data,
  output logic [ECC_PAR_W-1:0]  parity
);

  assign parity = ecc_parity(data);

endmodule

// File: rtl/ecc_err_log.sv
// Scrub error log: saturating per-pass count, last error address, irq pulse.
module ecc_err_log #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              err,
  input  logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic              err_irq
);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count     <= '0;
      last_err_addr <= '0;
      err_irq       <= 1'b0;
    end else begin
      err_irq <= err;
      if (clr) begin
        err_count <= '0;
      end else if (err && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (err) begin
        last_err_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC memory scrubber: read, check, optionally correct each word.
// Define ECC_SCRUB_WRITEBACK_EN to write corrected words back to memory.
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int INTERVAL_W = 16,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [ECC_DATA_W-1:0] mem_wdata,
  output logic [ECC_PAR_W-1:0]  mem_wparity,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [ECC_DATA_W-1:0] mem_rdata,
  input  logic [ECC_PAR_W-1:0]  mem_rparity,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0]     last_err_addr,
  output logic                  err_irq
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  scrub_state_t state, state_nx;

  logic [ADDR_W-1:0]     addr;
  logic [INTERVAL_W-1:0] ivl_q;
  logic [INTERVAL_W-1:0] wait_cnt;
  logic [ECC_DATA_W-1:0] rdata_q;
  logic [ECC_PAR_W-1:0]  rpar_q;
  logic [ECC_DATA_W-1:0] cor_data;
  logic                  err_det;
  logic                  clr;
  logic                  err_stb;
  logic                  last;

  assign last    = (addr == LAST);
  assign clr     = (state == IDLE) && start;
  assign err_stb = (state == CHECK) && err_det;

  ecc_decoder u_dec (
    .data           (rdata_q),
    .parity         (rpar_q),
    .corrected_data (cor_data),
    .error_detected (err_det)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (interval != '0) ? WAIT : READ;
        end
      end
      WAIT: begin
        if (wait_cnt == INTERVAL_W'(1)) state_nx = READ;
      end
      READ: begin
        if (mem_gnt) state_nx = RDATA;
      end
      RDATA: begin
        if (mem_rvalid) state_nx = CHECK;
      end
      CHECK: begin
`ifdef ECC_SCRUB_WRITEBACK_EN
        state_nx = err_det ? WRITE : NEXT;
`else
        state_nx = NEXT;
`endif
      end
`ifdef ECC_SCRUB_WRITEBACK_EN
      WRITE: begin
        if (mem_gnt) state_nx = NEXT;
      end
`endif
      NEXT: begin
        if (last) begin
          state_nx = IDLE;
        end else begin
          state_nx = (ivl_q != '0) ? WAIT : READ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      ivl_q    <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      rpar_q   <= '0;
    end else begin
      state <= state_nx;
      if (clr) begin
        addr     <= '0;
        ivl_q    <= interval;
        wait_cnt <= interval;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - INTERVAL_W'(1);
      end
      if ((state == RDATA) && mem_rvalid) begin
        rdata_q <= mem_rdata;
        rpar_q  <= mem_rparity;
      end
      // Wrap to 0 after the last word so the next pass starts clean.
      if (state == NEXT) begin
        if (last) begin
          addr <= '0;
        end else begin
          addr     <= addr + ADDR_W'(1);
          wait_cnt <= ivl_q;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == NEXT) && last;
  assign mem_req  = (state == READ) || (state == WRITE);
  assign mem_addr = addr;

`ifdef ECC_SCRUB_WRITEBACK_EN
  logic [ECC_PAR_W-1:0]  enc_par;
  logic [ECC_DATA_W-1:0] wdata_q;
  logic [ECC_PAR_W-1:0]  wpar_q;

  ecc_encoder u_enc (
    .data   (cor_data),
    .parity (enc_par)
  );

  // Captured once in CHECK so the write bundle is frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q <= '0;
      wpar_q  <= '0;
    end else if (err_stb) begin
      wdata_q <= cor_data;
      wpar_q  <= enc_par;
    end
  end

  assign mem_we      = (state == WRITE);
  assign mem_wdata   = wdata_q;
  assign mem_wparity = wpar_q;
`else
  logic unused_cor;
  assign unused_cor  = ^cor_data;
  assign mem_we      = 1'b0;
  assign mem_wdata   = '0;
  assign mem_wparity = '0;
`endif

  ecc_err_log #(
    .ADDR_W (ADDR_W),
    .CNT_W  (ERR_CNT_W)
  ) u_log (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .err           (err_stb),
    .addr          (addr),
    .err_count     (err_count),
    .last_err_addr (last_err_addr),
    .err_irq       (err_irq)
  );

endmodule
